// File: rtl/cc_unit.sv
// cc_unit: Y86-64 condition-code register and jXX/cmovXX condition evaluator.
// Flags are captured from the ALU result/overflow on an accepted set_cc and
// the condition output is always computed from the stored flags, so a branch
// in execute sees the flags of the older OPq, not the one writing this cycle.
module cc_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_cc,
  input  logic        exc_block,
  input  logic [63:0] alu_result,
  input  logic        alu_ovf,
  input  logic [3:0]  ifun,
  output logic [2:0]  cc_out,
  output logic        cnd,
  output logic        cc_upd
);

  typedef enum logic {HOLD, UPDATE} wr_state_e;

  // Condition function codes
  localparam logic [3:0] C_ALW = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  wr_state_e  state_q;
  logic [2:0] cc_q, cc_d;   // {ZF, SF, OF}
  logic       we;
  logic       zf, sf, of, lt;

  // An exception/halt in flight must never let a younger OPq touch the flags.
  assign we   = set_cc & ~exc_block;
  assign cc_d = {(alu_result == 64'h0), alu_result[63], alu_ovf};

  // Flag register plus the HOLD/UPDATE write state that drives cc_upd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q    <= 3'b100;
      state_q <= HOLD;
    end else begin
      state_q <= we ? UPDATE : HOLD;
      if (we) cc_q <= cc_d;
    end
  end

  assign cc_out = cc_q;
  assign cc_upd = (state_q == UPDATE);

  assign zf = cc_q[2];
  assign sf = cc_q[1];
  assign of = cc_q[0];
  assign lt = sf ^ of;

  // Condition evaluation strictly from the stored flags; codes 7-15 give 0.
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_ALW:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule
